// File: rtl/fir_ss_feeder.sv
// fir_ss_feeder
//   Wishbone-slave register window that queues 32-bit samples in a small
//   FIFO and streams a programmed number of them out on an AXI-Stream
//   master toward the fir ss_* slave.
//
//   Register window (offsets from ADDR_BASE):
//     0x0 CTRL   W   bit0 start, bit1 clear (clear wins over start)
//     0x4 LEN    R/W bits[15:0] beats per run; writes ignored while running
//     0x8 DATA   W   push one sample (stalls, no ack, while FIFO is full)
//     0xC STATUS R   {sent_count[15:0], 3'b0, fifo_count[4:0], 4'b0,
//                     fifo_empty, fifo_full, done, busy}
//
// Ports
//   clk, rst                 sole clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i     Wishbone request qualifiers
//   wbs_sel_i                ignored, full-word access only
//   wbs_adr_i, wbs_dat_i     Wishbone address / write data
//   wbs_ack_o, wbs_dat_o     one-cycle ack, read data valid only with ack
//   ss_tvalid/tdata/tlast    AXI-Stream master outputs
//   ss_tready                AXI-Stream ready from the fir
//
// FSM
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start with LEN != 0; FIFO may be preloaded
//   RUN    | streaming FIFO head words until LEN beats handshaken
//   DONE   | one-cycle marker after the last beat, returns to IDLE

module fir_ss_feeder #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ss_tvalid,
  output logic [31:0] ss_tdata,
  output logic        ss_tlast,
  input  logic        ss_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [15:0]   len_q;
  logic [15:0]   sent_q;
  logic          done_q;
  logic          ack_q;
  logic [31:0]   dat_q;

  logic          unused_ok;
  assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

  // ---------------------------------------------------------------
  // Address decode and bus acceptance
  // ---------------------------------------------------------------
  logic        req;
  logic        hit;
  logic [1:0]  off;
  logic        sel_ctrl, sel_len, sel_data, sel_stat;
  logic        data_wr_req;
  logic        blocked;
  logic        accept, wr_acc, rd_acc;
  logic        ctrl_wr, clear, start_go, len_wr, push, pop;
  logic        fifo_full, fifo_empty;
  logic        beat_last;
  logic [4:0]  count5;
  logic [31:0] status;
  logic [31:0] rd_data;

  assign req  = wbs_cyc_i & wbs_stb_i;
  assign hit  = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign off  = wbs_adr_i[3:2];

  assign sel_ctrl = hit & (off == 2'd0);
  assign sel_len  = hit & (off == 2'd1);
  assign sel_data = hit & (off == 2'd2);
  assign sel_stat = hit & (off == 2'd3);

  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);

  assign ss_tvalid = (state_q == S_RUN) & ~fifo_empty;
  assign ss_tdata  = mem[rd_ptr];
  assign beat_last = (sent_q == (len_q - 16'd1));
  assign ss_tlast  = ss_tvalid & beat_last;
  assign pop       = ss_tvalid & ss_tready;

  // A full FIFO only stalls a DATA write when nothing leaves this cycle;
  // with a concurrent pop the slot frees at the same edge the push lands.
  assign data_wr_req = req & wbs_we_i & sel_data;
  assign blocked     = data_wr_req & fifo_full & ~pop;

  // ack_q masks re-acceptance while the master still holds the request
  // during the ack cycle, which also guarantees ack drops for a cycle.
  assign accept = req & ~ack_q & ~blocked;
  assign wr_acc = accept & wbs_we_i;
  assign rd_acc = accept & ~wbs_we_i;

  assign ctrl_wr  = wr_acc & sel_ctrl;
  assign clear    = ctrl_wr & wbs_dat_i[1];
  assign start_go = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1] &
                    (state_q == S_IDLE) & (len_q != 16'd0);
  assign len_wr   = wr_acc & sel_len & (state_q != S_RUN);
  assign push     = wr_acc & sel_data;

  assign count5 = 5'(fifo_count);
  assign status = {sent_q, 3'b000, count5, 4'b0000,
                   fifo_empty, fifo_full, done_q, (state_q == S_RUN)};

  always_comb begin
    rd_data = 32'h0;
    if (sel_len) begin
      rd_data = {16'h0, len_q};
    end else if (sel_stat) begin
      rd_data = status;
    end
  end

  // ---------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_go) state_d = S_RUN;
      S_RUN:  if (pop && beat_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      len_q      <= 16'h0;
      sent_q     <= 16'h0;
      done_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= accept;
      dat_q   <= rd_acc ? rd_data : 32'h0;

      if (len_wr) begin
        len_q <= wbs_dat_i[15:0];
      end

      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        sent_q     <= 16'h0;
        done_q     <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase

        if (start_go) begin
          sent_q <= 16'h0;
          done_q <= 1'b0;
        end else if (pop) begin
          sent_q <= sent_q + 16'd1;
          if (beat_last) begin
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wbs_dat_i;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_fir_ss_feeder.sv
// tb_fir_ss_feeder
//   Directed bench for fir_ss_feeder: a register-access vector table
//   followed by hand-written multi-cycle streaming sequences.

module tb_fir_ss_feeder;

  localparam logic [31:0] BASE   = 32'h0000_0080;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_LEN  = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;
  localparam logic [31:0] A_OUT  = BASE + 32'h40;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;

  fir_ss_feeder #(.DEPTH(8), .ADDR_BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Beat log and stall-stability monitor
  logic [31:0] bq_data[$];
  logic        bq_last[$];
  logic        stalled = 1'b0;
  logic [31:0] st_d = 32'h0;
  logic        st_l = 1'b0;

  always @(negedge clk) begin
    if (stalled && ss_tvalid) begin
      chk("stall_data", ss_tdata, st_d);
      chk("stall_last", 32'(ss_tlast), 32'(st_l));
    end
    if (ss_tvalid && ss_tready) begin
      bq_data.push_back(ss_tdata);
      bq_last.push_back(ss_tlast);
    end
    stalled = ss_tvalid && !ss_tready;
    st_d    = ss_tdata;
    st_l    = ss_tlast;
  end

  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    logic acked;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    acked = 1'b0;
    rd = 32'h0;
    for (int i = 0; i < 40 && !acked; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1;
        rd = rdat;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("wb_acked", 32'(acked), 32'd1);
    chk("ack_single", 32'(ack), 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(1'b1, a, d, dummy);
  endtask

  task automatic wb_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_cycle(1'b0, a, 32'h0, rd);
    chk(name, rd, exp);
  endtask

  task automatic chk_beats(input string name, input int n, input logic [31:0] first,
                           input logic [31:0] step);
    chk({name, "_count"}, 32'(bq_data.size()), 32'(n));
    for (int i = 0; i < n && i < bq_data.size(); i++) begin
      chk({name, "_data"}, bq_data[i], first + step * 32'(i));
      chk({name, "_last"}, 32'(bq_last[i]), 32'(i == n - 1));
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && bq_data.size() < n; i++) begin
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_ready(input int n);
    @(posedge clk); #1;
    ss_tready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    ss_tready = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic        acked;
    logic [3:0]  pat;

    tbl[0]  = '{1'b0, A_STAT, 32'h0,         32'h0000_0008};
    tbl[1]  = '{1'b0, A_LEN,  32'h0,         32'h0000_0000};
    tbl[2]  = '{1'b1, A_LEN,  32'hABCD_0004, 32'h0};
    tbl[3]  = '{1'b0, A_LEN,  32'h0,         32'h0000_0004};
    tbl[4]  = '{1'b0, A_CTRL, 32'h0,         32'h0000_0000};
    tbl[5]  = '{1'b0, A_DATA, 32'h0,         32'h0000_0000};
    tbl[6]  = '{1'b1, A_OUT,  32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{1'b0, A_OUT,  32'h0,         32'h0000_0000};
    tbl[8]  = '{1'b0, 32'h0,  32'h0,         32'h0000_0000};
    tbl[9]  = '{1'b1, A_CTRL, 32'h0,         32'h0};
    tbl[10] = '{1'b0, A_STAT, 32'h0,         32'h0000_0008};
    tbl[11] = '{1'b1, A_LEN,  32'h0,         32'h0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    adr = 32'h0; wdat = 32'h0; ss_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack",    32'(ack),       32'd0);
    chk("rst_dat",    rdat,           32'h0);
    chk("rst_tvalid", 32'(ss_tvalid), 32'd0);
    chk("rst_tlast",  32'(ss_tlast),  32'd0);

    // Register access table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].w) wb_write(tbl[i].a, tbl[i].d);
      else          wb_read("tbl_read", tbl[i].a, tbl[i].exp);
    end

    // Basic run
    ss_tready = 1'b1;
    wb_write(A_LEN, 32'd4);
    for (int i = 1; i <= 4; i++) wb_write(A_DATA, 32'(i));
    bq_data.delete(); bq_last.delete();
    wb_write(A_CTRL, 32'h1);
    wait_beats(4, 40);
    chk_beats("basic", 4, 32'd1, 32'd1);
    wb_read("basic_status", A_STAT, 32'h0004_000A);

    // Backpressure 1-0-0-1
    ss_tready = 1'b0;
    wb_write(A_LEN, 32'd3);
    wb_write(A_DATA, 32'd10);
    wb_write(A_DATA, 32'd20);
    wb_write(A_DATA, 32'd30);
    bq_data.delete(); bq_last.delete();
    wb_write(A_CTRL, 32'h1);
    pat = 4'b1001;
    for (int i = 0; i < 40 && bq_data.size() < 3; i++) begin
      @(posedge clk); #1;
      ss_tready = pat[i % 4];
    end
    @(posedge clk); #1;
    ss_tready = 1'b0;
    repeat (4) @(negedge clk);
    chk_beats("bp", 3, 32'd10, 32'd10);
    wb_read("bp_status", A_STAT, 32'h0003_000A);

    // Full FIFO: ninth push waits for a pop
    wb_write(A_LEN, 32'd9);
    for (int i = 0; i < 8; i++) wb_write(A_DATA, 32'h200 + 32'(i));
    bq_data.delete(); bq_last.delete();
    wb_write(A_CTRL, 32'h1);
    wb_read("full_status0", A_STAT, 32'h0000_0805);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_DATA; wdat = 32'h208;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    chk("full_hold_noack", 32'(seen), 32'd0);
    @(posedge clk); #1;
    ss_tready = 1'b1;
    @(posedge clk); #1;
    ss_tready = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 5 && !acked; i++) begin
      @(negedge clk);
      if (ack) acked = 1'b1;
    end
    chk("full_ack", 32'(acked), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("full_ack_single", 32'(ack), 32'd0);
    chk("full_beats", 32'(bq_data.size()), 32'd1);
    if (bq_data.size() > 0) chk("full_beat_data", bq_data[0], 32'h200);
    wb_read("full_status1", A_STAT, 32'h0001_0805);
    wb_write(A_CTRL, 32'h2);
    wb_read("full_cleared", A_STAT, 32'h0000_0008);

    // LEN=0 start is ignored
    ss_tready = 1'b1;
    wb_write(A_LEN, 32'd0);
    wb_write(A_DATA, 32'h300);
    wb_write(A_CTRL, 32'h1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ss_tvalid) seen = 1'b1;
    end
    chk("len0_tvalid", 32'(seen), 32'd0);
    wb_read("len0_status", A_STAT, 32'h0000_0100);
    wb_write(A_CTRL, 32'h2);

    // LEN=2 with five words queued
    wb_write(A_LEN, 32'd2);
    for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'd100 + 32'(i));
    bq_data.delete(); bq_last.delete();
    wb_write(A_CTRL, 32'h1);
    wait_beats(2, 30);
    chk_beats("len2", 2, 32'd100, 32'd1);
    wb_read("len2_status", A_STAT, 32'h0002_0302);

    // Reset mid-run
    ss_tready = 1'b0;
    wb_write(A_CTRL, 32'h2);
    wb_write(A_LEN, 32'd6);
    for (int i = 0; i < 6; i++) wb_write(A_DATA, 32'h400 + 32'(i));
    bq_data.delete(); bq_last.delete();
    wb_write(A_CTRL, 32'h1);
    pulse_ready(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalid", 32'(ss_tvalid), 32'd0);
    chk("rst_mid_beats", 32'(bq_data.size()), 32'd2);
    wb_read("rst_mid_status", A_STAT, 32'h0000_0008);
    wb_read("rst_mid_len", A_LEN, 32'h0000_0000);

    // Clear during RUN
    wb_write(A_LEN, 32'd4);
    for (int i = 0; i < 4; i++) wb_write(A_DATA, 32'h500 + 32'(i));
    bq_data.delete(); bq_last.delete();
    wb_write(A_CTRL, 32'h1);
    pulse_ready(1);
    wb_write(A_LEN, 32'd7);
    wb_read("run_len_locked", A_LEN, 32'h0000_0004);
    wb_read("run_status", A_STAT, 32'h0001_0301);
    wb_write(A_CTRL, 32'h3);
    ss_tready = 1'b1;
    repeat (8) @(negedge clk);
    chk("clear_beats", 32'(bq_data.size()), 32'd1);
    wb_read("clear_status", A_STAT, 32'h0000_0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
